// File: rtl/msrv32_wb_arbiter.sv
// msrv32_wb_arbiter: round-robin writeback arbiter for the integer register file
// write port.
// N_REQ requesters compete through a valid/ready handshake. The winner is
// registered into a single output stage that drives wr_en/rd_addr/rd.
// Optional feature macro: MSRV32_WB_SCOREBOARD_EN adds a destination scoreboard
// that flags source registers with a write still outstanding.

module msrv32_wb_arbiter #(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned XLEN  = 32
) (
   input  logic                    clk_in,
   input  logic                    reset_n_in,
   input  logic                    flush_in,
   input  logic [N_REQ-1:0]        req_valid_in,
   output logic [N_REQ-1:0]        req_ready_out,
   input  logic [5*N_REQ-1:0]      req_addr_in,
   input  logic [XLEN*N_REQ-1:0]   req_data_in,
   output logic                    wr_en_out,
   output logic [4:0]              rd_addr_out,
   output logic [XLEN-1:0]         rd_out,
   input  logic                    sb_set_in,
   input  logic [4:0]              sb_set_addr_in,
   input  logic [4:0]              rs_1_addr_in,
   input  logic [4:0]              rs_2_addr_in,
   output logic                    rs_1_pending_out,
   output logic                    rs_2_pending_out
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] grant;
   logic             grant_any;
   logic [PW-1:0]    gidx;
   logic [4:0]       win_addr;
   logic [XLEN-1:0]  win_data;

   logic             wr_en_q;
   logic [4:0]       rd_addr_q;
   logic [XLEN-1:0]  rd_data_q;

   // Round-robin scan from the pointer upward; first valid requester wins.
   always_comb begin
      int idx;
      int nxt;
      grant     = '0;
      grant_any = 1'b0;
      gidx      = '0;
      idx       = 0;
      nxt       = 0;
      // No grant while reset is held or the pipeline is being flushed.
      if (reset_n_in && !flush_in) begin
         for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_REQ)) begin
               idx = idx - int'(N_REQ);
            end
            if (!grant_any && req_valid_in[idx]) begin
               grant[idx] = 1'b1;
               grant_any  = 1'b1;
               gidx       = PW'(idx);
            end
         end
      end
      win_addr = req_addr_in[5*int'(gidx) +: 5];
      win_data = req_data_in[XLEN*int'(gidx) +: XLEN];
      ptr_d    = ptr_q;
      if (grant_any) begin
         nxt = int'(gidx) + 1;
         if (nxt >= int'(N_REQ)) begin
            nxt = 0;
         end
         ptr_d = PW'(nxt);
      end
   end

   assign req_ready_out = grant;

   // Pointer and registered write-port stage; x0 writes retire without wr_en.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wr_en_q <= grant_any && (win_addr != 5'd0);
         if (grant_any) begin
            rd_addr_q <= win_addr;
            rd_data_q <= win_data;
         end
      end
   end

   assign wr_en_out   = wr_en_q;
   assign rd_addr_out = rd_addr_q;
   assign rd_out      = rd_data_q;

`ifdef MSRV32_WB_SCOREBOARD_EN
   logic [31:0] pend_q, pend_d;

   // Retiring write clears its bit; a same-cycle set is applied last so it wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_en_q) begin
         pend_d[rd_addr_q] = 1'b0;
      end
      if (sb_set_in && (sb_set_addr_in != 5'd0)) begin
         pend_d[sb_set_addr_in] = 1'b1;
      end
   end

   // Pending vector survives flush; only reset clears it.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign rs_1_pending_out = (rs_1_addr_in != 5'd0) && pend_q[rs_1_addr_in];
   assign rs_2_pending_out = (rs_2_addr_in != 5'd0) && pend_q[rs_2_addr_in];
`else
   logic unused_sb;
   assign unused_sb        = ^{sb_set_in, sb_set_addr_in, rs_1_addr_in, rs_2_addr_in};
   assign rs_1_pending_out = 1'b0;
   assign rs_2_pending_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Self-checking bench for msrv32_wb_arbiter (N_REQ=3, XLEN=32). Expected
// write-port values are pushed to a queue at grant time and popped one edge later.

module tb_msrv32_wb_arbiter;

   logic        clk_in = 1'b0;
   logic        reset_n_in;
   logic        flush_in;
   logic [2:0]  req_valid_in;
   logic [2:0]  req_ready_out;
   logic [14:0] req_addr_in;
   logic [95:0] req_data_in;
   logic        wr_en_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_out;
   logic        sb_set_in;
   logic [4:0]  sb_set_addr_in;
   logic [4:0]  rs_1_addr_in;
   logic [4:0]  rs_2_addr_in;
   logic        rs_1_pending_out;
   logic        rs_2_pending_out;

   msrv32_wb_arbiter #(.N_REQ(3), .XLEN(32)) dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .flush_in         (flush_in),
      .req_valid_in     (req_valid_in),
      .req_ready_out    (req_ready_out),
      .req_addr_in      (req_addr_in),
      .req_data_in      (req_data_in),
      .wr_en_out        (wr_en_out),
      .rd_addr_out      (rd_addr_out),
      .rd_out           (rd_out),
      .sb_set_in        (sb_set_in),
      .sb_set_addr_in   (sb_set_addr_in),
      .rs_1_addr_in     (rs_1_addr_in),
      .rs_2_addr_in     (rs_2_addr_in),
      .rs_1_pending_out (rs_1_pending_out),
      .rs_2_pending_out (rs_2_pending_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t        exp_q[$];
   int          n_err = 0;
   int          n_chk = 0;
   int          m_ptr = 0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int model_grant();
      int idx;
      if (!reset_n_in || flush_in) return -1;
      for (int k = 0; k < 3; k++) begin
         idx = (m_ptr + k) % 3;
         if (req_valid_in[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid_in[i]        = v;
      req_addr_in[5*i +: 5]  = a;
      req_data_in[32*i +: 32] = d;
   endtask

   // One clock: check grant, push expected output, advance, pop and compare.
   task automatic cycle();
      exp_t       e;
      int         g;
      logic [2:0] oh;
      #1;
      g  = model_grant();
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      check("ready", 64'(req_ready_out), 64'(oh));
      if (g >= 0) begin
         m_addr = req_addr_in[5*g +: 5];
         m_data = req_data_in[32*g +: 32];
         e.we   = (m_addr != 5'd0);
         m_ptr  = (g + 1) % 3;
      end else begin
         e.we = 1'b0;
      end
      e.a = m_addr;
      e.d = m_data;
      exp_q.push_back(e);
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check("wr_en", 64'(wr_en_out), 64'(e.we));
         check("rd_addr", 64'(rd_addr_out), 64'(e.a));
         check("rd", 64'(rd_out), 64'(e.d));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_in     = 1'b0;
      flush_in       = 1'b0;
      req_valid_in   = 3'b111;
      req_addr_in    = {5'd3, 5'd2, 5'd1};
      req_data_in    = {32'h3, 32'h2, 32'h1};
      sb_set_in      = 1'b0;
      sb_set_addr_in = '0;
      rs_1_addr_in   = '0;
      rs_2_addr_in   = '0;

      // Reset held with all requesters valid.
      #3;
      check("rst_ready", 64'(req_ready_out), 64'd0);
      check("rst_wr_en", 64'(wr_en_out), 64'd0);
      check("rst_addr", 64'(rd_addr_out), 64'd0);
      check("rst_rd", 64'(rd_out), 64'd0);
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      check("rst_clk_wr_en", 64'(wr_en_out), 64'd0);
      check("rst_clk_ready", 64'(req_ready_out), 64'd0);

      // First transfer after reset.
      reset_n_in   = 1'b1;
      req_valid_in = '0;
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      cycle();
      req_valid_in = '0;

      // Bring pointer back to 0 through one grant to requester 2.
      set_req(2, 1'b1, 5'd12, 32'h0000_2222);
      cycle();
      req_valid_in = '0;

      // Round-robin with all valid: 0,1,2,0,1,2.
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(j * 16 + i));
         end
         #1;
         check("rr_order", 64'(req_ready_out), 64'(3'b001 << (j % 3)));
         cycle();
      end
      req_valid_in = '0;

      // x0 write retires but does not assert wr_en; pointer moves to 2.
      set_req(1, 1'b1, 5'd0, 32'h0000_1234);
      cycle();
      req_valid_in = 3'b111;
      #1;
      check("x0_ptr", 64'(req_ready_out), 64'(3'b100));
      cycle();
      req_valid_in = '0;

      // Flush blocks grants for two cycles, then requester 2 wins.
      set_req(2, 1'b1, 5'd3, 32'hF00D_0003);
      flush_in = 1'b1;
      cycle();
      cycle();
      flush_in = 1'b0;
      cycle();
      req_valid_in = '0;

      // Idle cycle: wr_en drops, address/data hold.
      cycle();

      // Reset mid-transfer clears the output stage at once and the pointer.
      set_req(0, 1'b1, 5'd9, 32'h5555_5555);
      cycle();
      req_valid_in = '0;
      #2;
      reset_n_in = 1'b0;
      #1;
      check("mid_rst_wr_en", 64'(wr_en_out), 64'd0);
      check("mid_rst_addr", 64'(rd_addr_out), 64'd0);
      check("mid_rst_rd", 64'(rd_out), 64'd0);
      @(posedge clk_in);
      #1;
      reset_n_in = 1'b1;
      m_ptr  = 0;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(20 + i), 32'hC0DE_0000 + 32'(i));
      cycle();
      req_valid_in = '0;

`ifdef MSRV32_WB_SCOREBOARD_EN
      rs_1_addr_in   = 5'd7;
      rs_2_addr_in   = 5'd7;
      sb_set_in      = 1'b1;
      sb_set_addr_in = 5'd7;
      #1;
      check("sb_before_set", 64'(rs_1_pending_out), 64'd0);
      cycle();
      sb_set_in = 1'b0;
      check("sb_set_rs1", 64'(rs_1_pending_out), 64'd1);
      check("sb_set_rs2", 64'(rs_2_pending_out), 64'd1);
      set_req(0, 1'b1, 5'd7, 32'h7777_0007);
      cycle();
      req_valid_in = '0;
      check("sb_during_wr", 64'(rs_1_pending_out), 64'd1);
      cycle();
      check("sb_cleared", 64'(rs_1_pending_out), 64'd0);
      // Set and clear of the same register in one cycle: set wins.
      sb_set_in = 1'b1;
      cycle();
      sb_set_in = 1'b0;
      set_req(1, 1'b1, 5'd7, 32'h7777_1007);
      cycle();
      req_valid_in = '0;
      sb_set_in    = 1'b1;
      cycle();
      sb_set_in = 1'b0;
      check("sb_set_wins", 64'(rs_1_pending_out), 64'd1);
      rs_2_addr_in = 5'd0;
      #1;
      check("sb_x0_forced", 64'(rs_2_pending_out), 64'd0);
`else
      sb_set_in      = 1'b1;
      sb_set_addr_in = 5'd7;
      rs_1_addr_in   = 5'd7;
      rs_2_addr_in   = 5'd7;
      for (int j = 0; j < 3; j++) begin
         cycle();
         check("nosb_rs1", 64'(rs_1_pending_out), 64'd0);
         check("nosb_rs2", 64'(rs_2_pending_out), 64'd0);
      end
      sb_set_in = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
